// File: rtl/pong_pkg.sv
// Shared definitions for the score display path: segment codes, converter
// state encoding and the double-dabble step used by the BCD converter.
package pong_pkg;

  localparam int SCORE_W = 7;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_SHIFT = 2'd1,
    SD_LATCH = 2'd2
  } sd_state_t;

  // Nibble correction applied before each shift
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // One shift-add-3 step on {tens, units, binary}
  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [14:0] adj;
    adj = {add3(s[14:11]), add3(s[10:7]), s[6:0]};
    return {adj[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score display bus: score/update/blink controls in, segment digits and status out.
interface score_display_if;

  logic [pong_pkg::SCORE_W-1:0] points;
  logic                         update;
  logic                         blink_en;
  logic                         blink_tick;
  logic [6:0]                   display0;
  logic [6:0]                   display1;
  logic                         busy;
  logic                         overflow;

  modport master (
    output points, update, blink_en, blink_tick,
    input  display0, display1, busy, overflow
  );

  modport slave (
    input  points, update, blink_en, blink_tick,
    output display0, display1, busy, overflow
  );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes stay dark.
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    // NOTE: every path assigns seg (default first), so no latch is inferred.
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Two-digit score display: saturating binary score -> BCD through a sequential
// double-dabble converter, latched into registered 7-segment outputs with an
// optional blink mask. One update may wait while a conversion is running.
module score_display
  import pong_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned MAX_SCORE      = 99
) (
  input  logic             clk,
  input  logic             rst,
  score_display_if.slave   sd
);

  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

  sd_state_t            state, state_n;
  logic                 load;
  logic [SCORE_W-1:0]   load_val;
  logic [14:0]          shreg;
  logic [2:0]           cnt;
  logic                 ovf_next;
  logic                 pend_valid;
  logic [SCORE_W-1:0]   pend_val;
  logic [3:0]           tens_q, units_q;
  logic [3:0]           tens_n, units_n;
  logic                 ovf_q;
  logic                 phase_on, phase_n;
  logic                 blink_en_q;
  logic                 blank_n;
  logic [6:0]           seg_tens, seg_units;
  logic [6:0]           disp0_q, disp1_q;

  // Blanking and output polarity applied on the way into the output registers
  function automatic logic [6:0] drive(input logic [6:0] seg, input logic blank);
    logic [6:0] s;
    s = blank ? SEG_OFF : seg;
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops update together.
    if (rst) state <= SD_IDLE;
    else     state <= state_n;
  end

  // Next state and conversion load selection
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      SD_IDLE: begin
        if (sd.update) begin
          load     = 1'b1;
          load_val = sd.points;
          state_n  = SD_SHIFT;
        end
      end
      SD_SHIFT: begin
        if (cnt == 3'd6) state_n = SD_LATCH;
      end
      SD_LATCH: begin
        // A fresh update arriving now is newer than anything pending
        if (sd.update) begin
          load     = 1'b1;
          load_val = sd.points;
          state_n  = SD_SHIFT;
        end else if (pend_valid) begin
          load     = 1'b1;
          load_val = pend_val;
          state_n  = SD_SHIFT;
        end else begin
          state_n  = SD_IDLE;
        end
      end
      default: state_n = SD_IDLE;
    endcase
  end

  // Converter datapath, pending slot and latched digits
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      ovf_next   <= 1'b0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (load) begin
        shreg    <= {8'd0, (load_val > MAX_VAL) ? MAX_VAL : load_val};
        cnt      <= '0;
        ovf_next <= (load_val > MAX_VAL);
      end else if (state == SD_SHIFT) begin
        shreg <= dd_step(shreg);
        cnt   <= cnt + 3'd1;
      end

      if (state == SD_LATCH) begin
        tens_q  <= shreg[14:11];
        units_q <= shreg[10:7];
        ovf_q   <= ovf_next;
      end

      // LATCH consumes the pending slot (or the direct update) itself
      if (state == SD_LATCH) begin
        pend_valid <= 1'b0;
      end else if (sd.update && state == SD_SHIFT) begin
        pend_valid <= 1'b1;
        pend_val   <= sd.points;
      end
    end
  end

  // Values the output registers will show after this edge
  always_comb begin
    tens_n  = tens_q;
    units_n = units_q;
    if (state == SD_LATCH) begin
      tens_n  = shreg[14:11];
      units_n = shreg[10:7];
    end
    phase_n = phase_on;
    if (blink_en_q && !sd.blink_en) phase_n = 1'b1;
    else if (sd.blink_tick)         phase_n = ~phase_on;
    blank_n = sd.blink_en && !phase_n;
  end

  seg7_decode u_dec_tens  (.bcd(tens_n),  .seg(seg_tens));
  seg7_decode u_dec_units (.bcd(units_n), .seg(seg_units));

  // Blink phase and registered segment outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_on   <= 1'b1;
      blink_en_q <= 1'b0;
      disp0_q    <= drive(SEG_0, 1'b0);
      disp1_q    <= drive(SEG_0, 1'b0);
    end else begin
      phase_on   <= phase_n;
      blink_en_q <= sd.blink_en;
      disp0_q    <= drive(seg_units, blank_n);
      disp1_q    <= drive(seg_tens,  blank_n);
    end
  end

  assign sd.display0 = disp0_q;
  assign sd.display1 = disp1_q;
  assign sd.busy     = (state != SD_IDLE);
  assign sd.overflow = ovf_q;

endmodule
